// File: rtl/hough_peak_finder.sv
// hough_peak_finder: scans the (theta, rho) vote accumulator once per frame,
// tracks the strongest bin and reports it on a valid/ready output. Optionally
// zeroes each bin in the cycle its data returns so the next frame starts clean.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; no accumulator traffic
// S_SCAN  | one read per cycle, theta-major, rho fastest
// S_DRAIN | last read data returns; last compare and last clear happen here
// S_REPORT| peak_* held stable, peak_valid high until peak_ready

module hough_peak_finder #(
    parameter int THETA_BINS    = 180,
    parameter int RHO_BINS      = 512,
    parameter int VOTE_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 17,
    parameter int THRESHOLD     = 32,
    parameter int CLEAR_ON_READ = 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    output logic                  busy,
    output logic                  acc_rd_en,
    output logic [ADDR_WIDTH-1:0] acc_rd_addr,
    input  logic [VOTE_WIDTH-1:0] acc_rd_data,
    output logic                  acc_wr_en,
    output logic [ADDR_WIDTH-1:0] acc_wr_addr,
    output logic [VOTE_WIDTH-1:0] acc_wr_data,
    output logic                  peak_valid,
    input  logic                  peak_ready,
    output logic [7:0]            peak_theta,
    output logic [ADDR_WIDTH-1:0] peak_rho,
    output logic [VOTE_WIDTH-1:0] peak_votes,
    output logic                  peak_found,
    output logic                  done
);

    localparam int RHO_W = (RHO_BINS > 1) ? $clog2(RHO_BINS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Read-side address counters
    logic [7:0]            theta_q;
    logic [RHO_W-1:0]      rho_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  last_addr;
    logic                  start_ok;

    // Tag of the read in flight, aligned with acc_rd_data
    logic                  tag_vld_q;
    logic [7:0]            tag_theta_q;
    logic [RHO_W-1:0]      tag_rho_q;
    logic [ADDR_WIDTH-1:0] tag_addr_q;

    // Running maximum and the candidate after this cycle's compare
    logic [VOTE_WIDTH-1:0] max_votes_q;
    logic [7:0]            max_theta_q;
    logic [RHO_W-1:0]      max_rho_q;
    logic                  take;
    logic [VOTE_WIDTH-1:0] cand_votes;
    logic [7:0]            cand_theta;
    logic [RHO_W-1:0]      cand_rho;

    // Terminal-address detect, start qualification and strict-greater compare
    always_comb begin
        last_addr  = (theta_q == 8'(THETA_BINS - 1)) && (rho_q == RHO_W'(RHO_BINS - 1));
        start_ok   = (state_q == S_IDLE) && start;
        take       = tag_vld_q && (acc_rd_data > max_votes_q);
        cand_votes = take ? acc_rd_data : max_votes_q;
        cand_theta = take ? tag_theta_q : max_theta_q;
        cand_rho   = take ? tag_rho_q   : max_rho_q;
    end

    // State register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start)      state_d = S_SCAN;
            S_SCAN:   if (last_addr)  state_d = S_DRAIN;
            S_DRAIN:                  state_d = S_REPORT;
            S_REPORT: if (peak_ready) state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // Scan address counters: rho fastest, wrap into theta; linear address kept alongside
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            theta_q <= '0;
            rho_q   <= '0;
            addr_q  <= '0;
        end else if (start_ok) begin
            theta_q <= '0;
            rho_q   <= '0;
            addr_q  <= '0;
        end else if ((state_q == S_SCAN) && !last_addr) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            if (rho_q == RHO_W'(RHO_BINS - 1)) begin
                rho_q   <= '0;
                theta_q <= theta_q + 8'd1;
            end else begin
                rho_q <= rho_q + RHO_W'(1);
            end
        end
    end

    // Delay the read tag one cycle so it lines up with the returned data
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            tag_vld_q   <= 1'b0;
            tag_theta_q <= '0;
            tag_rho_q   <= '0;
            tag_addr_q  <= '0;
        end else begin
            tag_vld_q   <= (state_q == S_SCAN);
            tag_theta_q <= theta_q;
            tag_rho_q   <= rho_q;
            tag_addr_q  <= addr_q;
        end
    end

    // Running max; cleared on each accepted start so ties favour the earliest bin
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            max_votes_q <= '0;
            max_theta_q <= '0;
            max_rho_q   <= '0;
        end else if (start_ok) begin
            max_votes_q <= '0;
            max_theta_q <= '0;
            max_rho_q   <= '0;
        end else if (take) begin
            max_votes_q <= acc_rd_data;
            max_theta_q <= tag_theta_q;
            max_rho_q   <= tag_rho_q;
        end
    end

    // Result registers, loaded once at the end of DRAIN and held through REPORT
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            peak_theta <= '0;
            peak_rho   <= '0;
            peak_votes <= '0;
            peak_found <= 1'b0;
        end else if (state_q == S_DRAIN) begin
            peak_theta <= cand_theta;
            peak_rho   <= ADDR_WIDTH'(cand_rho);
            peak_votes <= cand_votes;
            peak_found <= (cand_votes >= VOTE_WIDTH'(THRESHOLD));
        end
    end

    // Accumulator and handshake outputs; the clear trails the read by one
    // address, so a read and a clear never collide on the same bin
    always_comb begin
        busy        = (state_q != S_IDLE);
        acc_rd_en   = (state_q == S_SCAN);
        acc_rd_addr = addr_q;
        acc_wr_en   = (CLEAR_ON_READ != 0) && tag_vld_q;
        acc_wr_addr = tag_addr_q;
        acc_wr_data = '0;
        peak_valid  = (state_q == S_REPORT);
        done        = (state_q == S_REPORT) && peak_ready;
    end

endmodule

// File: tb/tb_hough_peak_finder.sv
// Directed bench for hough_peak_finder with a 4x8 accumulator model.

module tb_hough_peak_finder;

    localparam int TB = 4;
    localparam int RB = 8;
    localparam int NB = TB * RB;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic        busy;
    logic        acc_rd_en;
    logic [16:0] acc_rd_addr;
    logic [15:0] acc_rd_data;
    logic        acc_wr_en;
    logic [16:0] acc_wr_addr;
    logic [15:0] acc_wr_data;
    logic        peak_valid;
    logic        peak_ready = 1'b0;
    logic [7:0]  peak_theta;
    logic [16:0] peak_rho;
    logic [15:0] peak_votes;
    logic        peak_found;
    logic        done;

    int errs = 0;
    int checks = 0;
    int collide = 0;

    logic [15:0] mem    [0:NB-1];
    logic [15:0] ld_img [0:NB-1];
    logic        ld_go = 1'b0;

    hough_peak_finder #(
        .THETA_BINS(TB), .RHO_BINS(RB), .VOTE_WIDTH(16), .ADDR_WIDTH(17),
        .THRESHOLD(10), .CLEAR_ON_READ(1)
    ) dut (
        .aclk(aclk), .areset(areset), .start(start), .busy(busy),
        .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr), .acc_rd_data(acc_rd_data),
        .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
        .peak_valid(peak_valid), .peak_ready(peak_ready), .peak_theta(peak_theta),
        .peak_rho(peak_rho), .peak_votes(peak_votes), .peak_found(peak_found),
        .done(done)
    );

    always #5 aclk = ~aclk;

    // Accumulator RAM model: 1-cycle read latency, write port, bulk load between scans
    always @(posedge aclk) begin
        if (ld_go) begin
            for (int i = 0; i < NB; i++) mem[i] <= ld_img[i];
        end else if (acc_wr_en) begin
            mem[acc_wr_addr[4:0]] <= acc_wr_data;
        end
        if (acc_rd_en) acc_rd_data <= mem[acc_rd_addr[4:0]];
    end

    always @(negedge aclk) begin
        if (acc_rd_en && acc_wr_en && (acc_rd_addr == acc_wr_addr)) collide++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic img_fill(input logic [15:0] v);
        for (int i = 0; i < NB; i++) ld_img[i] = v;
    endtask

    task automatic load_mem();
        ld_go = 1'b1;
        @(negedge aclk);
        ld_go = 1'b0;
    endtask

    task automatic mem_zero_chk(input string tag);
        int nz;
        nz = 0;
        for (int i = 0; i < NB; i++) if (mem[i] != 16'd0) nz++;
        chk(tag, 32'(nz), 0);
    endtask

    task automatic run_scan(input string tag, input int et, input int er,
                            input int ev, input int ef);
        int cnt;
        cnt = 0;
        start = 1'b1;
        while (!peak_valid && cnt < 200) begin
            @(negedge aclk);
            cnt++;
            start = 1'b0;
            if (cnt == 1) begin
                chk({tag, "_rd_en0"}, 32'(acc_rd_en), 1);
                chk({tag, "_addr0"}, 32'(acc_rd_addr), 0);
            end
        end
        chk({tag, "_latency"}, 32'(cnt), 34);
        chk({tag, "_theta"}, 32'(peak_theta), 32'(et));
        chk({tag, "_rho"}, 32'(peak_rho), 32'(er));
        chk({tag, "_votes"}, 32'(peak_votes), 32'(ev));
        chk({tag, "_found"}, 32'(peak_found), 32'(ef));
    endtask

    task automatic handshake(input string tag);
        peak_ready = 1'b1;
        #1;
        chk({tag, "_done"}, 32'(done), 1);
        @(negedge aclk);
        peak_ready = 1'b0;
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_done_after"}, 32'(done), 0);
    endtask

    initial begin
        int bad;
        int dones;
        logic [7:0]  s_theta;
        logic [16:0] s_rho;
        logic [15:0] s_votes;
        logic        s_found;

        // 1: reset and quiet idle
        img_fill(16'd0);
        repeat (3) @(negedge aclk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(peak_valid), 0);
        areset = 1'b0;
        load_mem();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (acc_rd_en || acc_wr_en || busy || peak_valid || done) bad++;
            if (peak_theta != 0 || peak_rho != 0 || peak_votes != 0 || peak_found) bad++;
        end
        chk("idle_quiet", 32'(bad), 0);

        // 2: single strong bin
        img_fill(16'd0);
        ld_img[2*RB+5] = 16'd37;
        load_mem();
        run_scan("single", 2, 5, 37, 1);
        handshake("single");
        mem_zero_chk("single_cleared");

        // 3: tie, earliest in scan order wins
        img_fill(16'd7);
        ld_img[0*RB+3] = 16'd20;
        ld_img[3*RB+1] = 16'd20;
        load_mem();
        run_scan("tie", 0, 3, 20, 1);
        handshake("tie");
        mem_zero_chk("tie_cleared");

        // 4: peak below threshold
        for (int i = 0; i < NB; i++) ld_img[i] = 16'(i % 5);
        ld_img[1*RB+6] = 16'd5;
        load_mem();
        run_scan("below", 1, 6, 5, 0);
        handshake("below");

        // 5: back-pressure, stray start, handshake with simultaneous start
        img_fill(16'd0);
        ld_img[3*RB+6] = 16'd12;
        load_mem();
        run_scan("hold", 3, 6, 12, 1);
        s_theta = peak_theta; s_rho = peak_rho; s_votes = peak_votes; s_found = peak_found;
        bad = 0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            start = (i == 4);
            @(negedge aclk);
            if (!peak_valid || peak_theta != s_theta || peak_rho != s_rho ||
                peak_votes != s_votes || peak_found != s_found || acc_rd_en) bad++;
            if (done) dones++;
        end
        start = 1'b0;
        chk("hold_stable", 32'(bad), 0);
        chk("hold_no_done", 32'(dones), 0);
        start = 1'b1;
        handshake("hold");
        start = 1'b0;
        @(negedge aclk);
        chk("hold_start_ignored", 32'(busy), 0);
        chk("hold_no_read", 32'(acc_rd_en), 0);

        // all-zero accumulator reports (0,0,0) not found
        img_fill(16'd0);
        load_mem();
        run_scan("zero", 0, 0, 0, 0);
        handshake("zero");

        // 6: reset mid-scan, then a clean rescan
        img_fill(16'd0);
        ld_img[1*RB+1] = 16'd50;
        load_mem();
        start = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        repeat (11) @(negedge aclk);
        areset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_rd_en", 32'(acc_rd_en), 0);
        chk("abort_wr_en", 32'(acc_wr_en), 0);
        @(negedge aclk);
        areset = 1'b0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (busy || acc_rd_en || acc_wr_en || peak_valid) bad++;
        end
        chk("abort_quiet", 32'(bad), 0);
        img_fill(16'd0);
        ld_img[3*RB+7] = 16'd99;
        load_mem();
        run_scan("rescan", 3, 7, 99, 1);
        handshake("rescan");
        mem_zero_chk("rescan_cleared");

        chk("no_rd_wr_collision", 32'(collide), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
